// File: rtl/itof.sv
// ============================================================================
// itof : int32 -> IEEE-754 binary32 conversion, one registered pipeline stage
//
// Converts a two's-complement signed 32-bit integer to single precision with
// round-to-nearest-even. The datapath is combinational from x to the single
// output register, so a new operand is accepted every clock and its result
// appears on y right after the sampling edge.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset (y -> 0)
//   x          in  32   signed integer operand
//   y          out 32   binary32 result {sign, exp[7:0], frac[22:0]}, registered
//   in_valid   in   1   (ITOF_VALID_EN only) operand qualifier; y holds when 0
//   out_valid  out  1   (ITOF_VALID_EN only) in_valid delayed to match y
//
// Configuration macro
//   ITOF_VALID_EN  : when defined, adds the in_valid/out_valid handshake.
//                    When undefined, y updates from x on every clock.
// ============================================================================
module itof (
    input  logic        clk,
    input  logic        rst,
`ifdef ITOF_VALID_EN
    input  logic        in_valid,
    output logic        out_valid,
`endif
    input  logic [31:0] x,
    output logic [31:0] y
);

    // ------------------------------------------------------------------
    // Sign / magnitude. Negating 0x8000_0000 wraps to itself, which read
    // as unsigned is exactly 2^31, so no special case is needed.
    // ------------------------------------------------------------------
    logic        w_sign;
    logic [31:0] w_mag;
    logic        w_zero;

    assign w_sign = x[31];
    assign w_mag  = w_sign ? (~x + 32'd1) : x;
    assign w_zero = (w_mag == 32'd0);

    // ------------------------------------------------------------------
    // Leading-one position. Scanning upward and letting later hits
    // overwrite earlier ones leaves the highest set bit in w_p.
    // ------------------------------------------------------------------
    logic [4:0] w_p;

    always_comb begin
        w_p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (w_mag[i]) w_p = 5'(i);
        end
    end

    // ------------------------------------------------------------------
    // Normalise: move the leading one to bit 31. Bits [30:8] are then the
    // 23-bit fraction, bit 7 is the guard and [6:0] feed the sticky. For
    // p <= 23 the shift fills the low bits with zeros, so guard and sticky
    // are both 0 and the result is exact without a separate path.
    // ------------------------------------------------------------------
    logic [31:0] w_norm;
    logic [22:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_lsb;
    logic        w_inc;
    logic [7:0]  w_exp;

    assign w_norm   = w_mag << (5'd31 - w_p);
    assign w_frac   = w_norm[30:8];
    assign w_guard  = w_norm[7];
    assign w_sticky = |w_norm[6:0];
    assign w_lsb    = w_norm[8];
    assign w_inc    = w_guard & (w_sticky | w_lsb);
    assign w_exp    = 8'd127 + {3'b000, w_p};

    // ------------------------------------------------------------------
    // Round. Adding the increment to the concatenated {exp, frac} lets a
    // fraction carry-out ripple straight into the exponent, which is the
    // required frac=0 / exp+1 behaviour. Max exponent is 127+31+1 = 159
    // only in theory; the carry can only happen for p >= 24 with an
    // all-ones fraction, and p=31 gives at most 158 + carry from 0x7FFF_FFFF
    // style inputs whose p is 30, so the field never reaches 255.
    // ------------------------------------------------------------------
    logic [30:0] w_mag_bits;
    logic [31:0] w_res;

    assign w_mag_bits = {w_exp, w_frac} + {30'd0, w_inc};
    assign w_res      = w_zero ? 32'h0000_0000 : {w_sign, w_mag_bits};

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
`ifdef ITOF_VALID_EN
    logic [31:0] r_y;
    logic        r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y   <= 32'h0000_0000;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) r_y <= w_res;
        end
    end

    assign y         = r_y;
    assign out_valid = r_vld;
`else
    logic [31:0] r_y;

    always_ff @(posedge clk) begin
        if (rst) r_y <= 32'h0000_0000;
        else     r_y <= w_res;
    end

    assign y = r_y;
`endif

endmodule

// File: tb/tb_itof.sv
// ============================================================================
// tb_itof : self-checking bench for itof
//
// Reference conversion works on integer magnitudes (quotient/remainder
// against a half-ulp) rather than on shifted bit fields.
// ============================================================================
module tb_itof;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x   = 32'd0;
    logic [31:0] y;
`ifdef ITOF_VALID_EN
    logic        in_valid  = 1'b0;
    logic        out_valid;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    itof dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ITOF_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .x         (x),
        .y         (y)
    );

    // Behavioural int -> binary32 with round-to-nearest-even.
    function automatic logic [31:0] ref_cvt(input logic [31:0] v);
        longint m, q, rem, half;
        int     p, sh;
        logic   s;
        s = v[31];
        m = longint'($signed(v));
        if (m < 0) m = -m;
        if (m == 0) return 32'h0000_0000;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p++;
            end
        end
        return {s, 8'(127 + p), 23'(q)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // Apply one operand, clock it, check one cycle later.
    task automatic step(input string tag, input logic [31:0] v);
        x = v;
`ifdef ITOF_VALID_EN
        in_valid = 1'b1;
`endif
        @(posedge clk);
        #1;
        chk(tag, y, ref_cvt(v));
`ifdef ITOF_VALID_EN
        n_assert++;
        assert (out_valid === 1'b1) else begin
            n_fail++;
            $error("FAIL %s_vld observed=%b expected=1", tag, out_valid);
        end
`endif
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] held;

        // Reset for two edges with a nonzero operand present.
        rst = 1'b1;
        x   = 32'h1234_5678;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset", y, 32'h0000_0000);
        rst = 1'b0;
        #1;
        chk("post_reset_idle", y, 32'h0000_0000);

        // Directed values with hand-derived expectations.
        x = 32'd0;          @(posedge clk); #1; chk("zero",      y, 32'h0000_0000);
        x = 32'd1;          @(posedge clk); #1; chk("one",       y, 32'h3F80_0000);
        x = 32'hFFFF_FFFF;  @(posedge clk); #1; chk("minus_one", y, 32'hBF80_0000);
        x = 32'h8000_0000;  @(posedge clk); #1; chk("int_min",   y, 32'hCF00_0000);
        x = 32'h7FFF_FFFF;  @(posedge clk); #1; chk("int_max",   y, 32'h4F00_0000);
        x = 32'd16777217;   @(posedge clk); #1; chk("tie_down",  y, 32'h4B80_0000);
        x = 32'd16777219;   @(posedge clk); #1; chk("tie_up",    y, 32'h4B80_0002);
        x = 32'd16777215;   @(posedge clk); #1; chk("exact_p23", y, 32'h4B7F_FFFF);
        x = 32'd16777216;   @(posedge clk); #1; chk("pow2_24",   y, 32'h4B80_0000);
        x = -32'sd16777219; @(posedge clk); #1; chk("neg_tie",   y, 32'hCB80_0002);
        x = 32'd16777221;   @(posedge clk); #1; chk("tie_p24b",  y, 32'h4B80_0002);
        x = 32'd33554435;   @(posedge clk); #1; chk("above_half",y, 32'h4C00_0001);

        // Randomised stream, one operand per clock, half full-range and half
        // {sign, 21 zeros, 10 random bits}.
        for (int i = 0; i < 6000; i++) begin
            r = $urandom;
            if ($urandom_range(1, 0) == 1) r = {r[31], 21'd0, r[9:0]};
            step("rand", r);
            if (i == 3000) begin
                rst = 1'b1;
                x   = $urandom;
                @(posedge clk);
                #1;
                chk("mid_reset", y, 32'h0000_0000);
`ifdef ITOF_VALID_EN
                n_assert++;
                assert (out_valid === 1'b0) else begin
                    n_fail++;
                    $error("FAIL mid_reset_vld observed=%b expected=0", out_valid);
                end
`endif
                rst = 1'b0;
            end
        end

`ifdef ITOF_VALID_EN
        // With in_valid low the result register must hold.
        step("pre_hold", 32'd5);
        held     = ref_cvt(32'd5);
        x        = 32'd12345;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold", y, held);
        n_assert++;
        assert (out_valid === 1'b0) else begin
            n_fail++;
            $error("FAIL hold_vld observed=%b expected=0", out_valid);
        end
`else
        held = 32'd0;
        step("final", 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
